// File: rtl/ahbl_sram_ctrl_pipe_if.sv
// Request/response bus between the AHB-Lite slave front end and the SRAM control pipe.
// A request transfers on any cycle with req && ready; the master holds req and its fields stable until then.
interface ahbl_sram_ctrl_pipe_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 19
);
  logic              req;
  logic              write;
  logic [2:0]        size;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              ready;
  logic              ack;
  logic              err;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output req, write, size, addr, wdata,
    input  ready, ack, err, rdata
  );

  modport slave (
    input  req, write, size, addr, wdata,
    output ready, ack, err, rdata
  );
endinterface

// File: rtl/ahbl_sram_ctrl_pipe.sv
// SRAM control pipe: checks size/alignment, issues one-cycle memory strobes on accept,
// waits RD_LATENCY cycles for read data and returns a one-cycle ack (with err on illegal requests).
module ahbl_sram_ctrl_pipe #(
  parameter  int DWIDTH     = 32,
  parameter  int AWIDTH     = 19,
  parameter  int RD_LATENCY = 1,
  localparam int NBYTES     = DWIDTH / 8,
  localparam int LSB        = $clog2(NBYTES)
) (
  input  logic                    HCLK,
  input  logic                    aresetn,
  ahbl_sram_ctrl_pipe_if.slave    bus,
  input  logic                    mem_busy,
  output logic                    mem_wen,
  output logic                    mem_ren,
  output logic [AWIDTH-LSB-1:0]   mem_addr,
  output logic [NBYTES-1:0]       mem_byteen,
  output logic [DWIDTH-1:0]       mem_wdata,
  input  logic [DWIDTH-1:0]       mem_rdata,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACK  = 3'd1,
    RD_WAIT = 3'd2,
    RD_ACK  = 3'd3,
    ERR_ACK = 3'd4
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;

  logic                ready_w;
  logic                accept;
  logic                misalign;
  logic                illegal;
  int                  lane_lo;
  int                  lane_n;
  logic [NBYTES-1:0]   lane_mask;

  // Request decode: legality and the contiguous byte-lane window of the access.
  always_comb begin
    ready_w   = (state_q != RD_WAIT) && !mem_busy;
    accept    = bus.req && ready_w;
    misalign  = 1'b0;
    for (int i = 0; i < LSB; i++) begin
      if ((i < int'(bus.size)) && bus.addr[i]) misalign = 1'b1;
    end
    illegal   = (bus.size > 3'(LSB)) || misalign;
    lane_lo   = int'(bus.addr[LSB-1:0]);
    lane_n    = 1 << bus.size;
    lane_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      lane_mask[i] = (i >= lane_lo) && (i < lane_lo + lane_n);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    mem_wen    = 1'b0;
    mem_ren    = 1'b0;
    mem_byteen = '0;
    case (state_q)
      RD_WAIT: begin
        if (cnt_q == 3'd1) begin
          rdata_d = mem_rdata;
          cnt_d   = 3'd0;
          state_d = RD_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        // IDLE and the ack states share accept handling so a new request can follow an ack directly.
        state_d = IDLE;
        if (accept) begin
          if (illegal) begin
            state_d = ERR_ACK;
          end else if (bus.write) begin
            mem_wen    = 1'b1;
            mem_byteen = lane_mask;
            state_d    = WR_ACK;
          end else begin
            mem_ren = 1'b1;
            cnt_d   = LAT;
            state_d = RD_WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready = ready_w;
  assign bus.ack   = (state_q == WR_ACK) || (state_q == RD_ACK) || (state_q == ERR_ACK);
  assign bus.err   = (state_q == ERR_ACK);
  assign bus.rdata = rdata_q;
  assign mem_addr  = bus.addr[AWIDTH-1:LSB];
  assign mem_wdata = bus.wdata;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahbl_sram_ctrl_pipe.sv
// Bench for two pipe instances (32-bit/latency 1 and 64-bit/latency 3) against a byte-level memory model.
module tb_ahbl_sram_ctrl_pipe;

  logic clk;
  logic aresetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  b_req, b_write, b_busy;
  logic [2:0]  b_size  [2];
  logic [18:0] b_addr  [2];
  logic [63:0] b_wdata [2];
  logic [63:0] mem_rd  [2];

  logic [1:0]  o_ready, o_ack, o_err, o_wen, o_ren;
  logic [63:0] o_rdata  [2];
  logic [63:0] o_mwdata [2];
  logic [7:0]  o_byteen [2];
  logic [18:0] o_maddr  [2];
  logic [2:0]  o_state  [2];

  logic [16:0] m32_addr;
  logic [3:0]  m32_be;
  logic [31:0] m32_wdata;
  logic [15:0] m64_addr;
  logic [7:0]  m64_be;
  logic [63:0] m64_wdata;

  ahbl_sram_ctrl_pipe_if #(.DWIDTH(32), .AWIDTH(19)) if32 ();
  ahbl_sram_ctrl_pipe_if #(.DWIDTH(64), .AWIDTH(19)) if64 ();

  assign if32.req   = b_req[0];
  assign if32.write = b_write[0];
  assign if32.size  = b_size[0];
  assign if32.addr  = b_addr[0];
  assign if32.wdata = b_wdata[0][31:0];
  assign if64.req   = b_req[1];
  assign if64.write = b_write[1];
  assign if64.size  = b_size[1];
  assign if64.addr  = b_addr[1];
  assign if64.wdata = b_wdata[1];

  ahbl_sram_ctrl_pipe #(.DWIDTH(32), .AWIDTH(19), .RD_LATENCY(1)) u32 (
    .HCLK(clk), .aresetn(aresetn), .bus(if32.slave), .mem_busy(b_busy[0]),
    .mem_wen(o_wen[0]), .mem_ren(o_ren[0]), .mem_addr(m32_addr), .mem_byteen(m32_be),
    .mem_wdata(m32_wdata), .mem_rdata(mem_rd[0][31:0]), .dbg_state(o_state[0])
  );

  ahbl_sram_ctrl_pipe #(.DWIDTH(64), .AWIDTH(19), .RD_LATENCY(3)) u64 (
    .HCLK(clk), .aresetn(aresetn), .bus(if64.slave), .mem_busy(b_busy[1]),
    .mem_wen(o_wen[1]), .mem_ren(o_ren[1]), .mem_addr(m64_addr), .mem_byteen(m64_be),
    .mem_wdata(m64_wdata), .mem_rdata(mem_rd[1]), .dbg_state(o_state[1])
  );

  assign o_ready    = {if64.ready, if32.ready};
  assign o_ack      = {if64.ack, if32.ack};
  assign o_err      = {if64.err, if32.err};
  assign o_rdata[0] = {32'b0, if32.rdata};
  assign o_rdata[1] = if64.rdata;
  assign o_maddr[0] = {2'b0, m32_addr};
  assign o_maddr[1] = {3'b0, m64_addr};
  assign o_byteen[0] = {4'b0, m32_be};
  assign o_byteen[1] = m64_be;
  assign o_mwdata[0] = {32'b0, m32_wdata};
  assign o_mwdata[1] = m64_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nb_of(input int s);  return (s == 1) ? 8 : 4; endfunction
  function automatic int lsb_of(input int s); return (s == 1) ? 3 : 2; endfunction
  function automatic int lat_of(input int s); return (s == 1) ? 3 : 1; endfunction
  function automatic int key(input int s, input int a); return (s << 20) | a; endfunction

  logic [7:0] ref_mem  [int];
  logic [7:0] stub_mem [int];

  function automatic logic [63:0] ref_word(input int s, input int waddr);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < nb_of(s); i++)
      if (ref_mem.exists(key(s, waddr * nb_of(s) + i))) w[8*i +: 8] = ref_mem[key(s, waddr * nb_of(s) + i)];
    return w;
  endfunction

  function automatic logic [63:0] stub_word(input int s, input int waddr);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < nb_of(s); i++)
      if (stub_mem.exists(key(s, waddr * nb_of(s) + i))) w[8*i +: 8] = stub_mem[key(s, waddr * nb_of(s) + i)];
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SRAM stand-in: applies the DUT's strobes, and drives valid read data only in the cycle
  // RD_LATENCY after the read strobe, junk in every other cycle.
  int rcyc  [2] = '{0, 0};
  int raddr [2] = '{0, 0};
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (o_wen[s])
        for (int i = 0; i < nb_of(s); i++)
          if (o_byteen[s][i]) stub_mem[key(s, int'(o_maddr[s]) * nb_of(s) + i)] = o_mwdata[s][8*i +: 8];
      if (o_ren[s]) begin
        rcyc[s]  = 1;
        raddr[s] = int'(o_maddr[s]);
      end else if (rcyc[s] > 0 && rcyc[s] < lat_of(s)) begin
        rcyc[s]++;
      end else begin
        rcyc[s] = 0;
      end
      mem_rd[s] <= (rcyc[s] == lat_of(s)) ? stub_word(s, raddr[s]) : {$urandom, $urandom};
    end
  end

  typedef struct {
    int          s;
    int          cyc;
    bit          rd;
    bit          err;
    logic [63:0] rdata;
  } exp_t;
  exp_t        exp_q [$];
  logic [63:0] exp_rd [2];

  // Scoreboard monitor: ready, idle strobes and the exact ack cycle of every outstanding request.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      int idx;
      bit rdw;
      bit eack;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (idx < 0 && exp_q[i].s == s) idx = i;
      rdw  = (idx >= 0) && exp_q[idx].rd && (exp_q[idx].cyc > cyc);
      eack = (idx >= 0) && (exp_q[idx].cyc == cyc);
      check($sformatf("ready%0d", s), 64'(o_ready[s]), 64'(!b_busy[s] && !rdw));
      if (!(b_req[s] && o_ready[s]))
        check($sformatf("idle_strobe%0d", s), {o_wen[s], o_ren[s], o_byteen[s]}, 64'd0);
      check($sformatf("ack%0d", s), 64'(o_ack[s]), 64'(eack));
      if (eack) begin
        check($sformatf("err%0d", s), 64'(o_err[s]), 64'(exp_q[idx].err));
        check($sformatf("rdata%0d", s), o_rdata[s], exp_q[idx].rdata);
        exp_q.delete(idx);
      end else if (idx >= 0 && exp_q[idx].cyc < cyc) begin
        exp_q.delete(idx);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int s);
    b_req[s] = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that ends the accept cycle, req still high.
  task automatic accept(input int s, input bit wr, input logic [2:0] sz, input logic [18:0] ad,
                        input logic [63:0] wd, output int t_acc);
    bit          legal;
    int          lane;
    logic [63:0] m;
    if (s == 0) wd[63:32] = '0;
    b_req[s] = 1'b1; b_write[s] = wr; b_size[s] = sz; b_addr[s] = ad; b_wdata[s] = wd;
    @(negedge clk);
    for (int w = 0; w < 40 && !o_ready[s]; w++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check($sformatf("accept_timeout%0d", s), 64'(o_ready[s]), 64'd1);
    t_acc = cyc;
    legal = (int'(sz) <= lsb_of(s)) && ((int'(ad) % (1 << sz)) == 0);
    lane  = int'(ad) % nb_of(s);
    m     = ((64'd1 << (1 << sz)) - 64'd1) << lane;
    check($sformatf("wen%0d", s), 64'(o_wen[s]), 64'(legal && wr));
    check($sformatf("ren%0d", s), 64'(o_ren[s]), 64'(legal && !wr));
    check($sformatf("byteen%0d", s), 64'(o_byteen[s]), (legal && wr) ? 64'(m[7:0]) : 64'd0);
    check($sformatf("maddr%0d", s), 64'(o_maddr[s]), 64'(ad >> lsb_of(s)));
    check($sformatf("mwdata%0d", s), o_mwdata[s], wd);
    @(posedge clk);
    #1;
    if (!legal) begin
      exp_q.push_back('{s, t_acc + 1, 1'b0, 1'b1, exp_rd[s]});
    end else if (wr) begin
      for (int i = 0; i < (1 << sz); i++) ref_mem[key(s, int'(ad) + i)] = wd[8*(lane+i) +: 8];
      exp_q.push_back('{s, t_acc + 1, 1'b0, 1'b0, exp_rd[s]});
    end else begin
      exp_rd[s] = ref_word(s, int'(ad) / nb_of(s));
      exp_q.push_back('{s, t_acc + lat_of(s) + 1, 1'b1, 1'b0, exp_rd[s]});
    end
  endtask

  initial begin
    int t, t1, t2, t3, t4, s, ns;
    bit wr;
    logic [2:0] sz;
    logic [18:0] ad;
    aresetn = 1'b0;
    b_req = '0; b_write = '0; b_busy = '0;
    for (int i = 0; i < 2; i++) begin
      b_size[i] = '0; b_addr[i] = '0; b_wdata[i] = '0; exp_rd[i] = '0;
    end
    wait_cyc(2);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_rdata%0d", i), o_rdata[i], 64'd0);
      check($sformatf("rst_state%0d", i), 64'(o_state[i]), 64'd0);
      check($sformatf("rst_err%0d", i), 64'(o_err[i]), 64'd0);
    end
    @(posedge clk); #1;
    aresetn = 1'b1;
    wait_cyc(1);

    accept(0, 1'b1, 3'd2, 19'h10, 64'hDEADBEEF, t); idle(0); wait_cyc(2);
    accept(0, 1'b0, 3'd2, 19'h10, 64'h0, t);        idle(0); wait_cyc(3);
    check("rd_deadbeef", o_rdata[0], 64'hDEADBEEF);
    accept(0, 1'b1, 3'd0, 19'h13, 64'hAA000000, t); idle(0); wait_cyc(2);
    accept(0, 1'b1, 3'd1, 19'h12, 64'h55660000, t); idle(0); wait_cyc(2);
    accept(0, 1'b1, 3'd1, 19'h11, 64'h1234, t);     idle(0); wait_cyc(2);
    accept(0, 1'b0, 3'd3, 19'h08, 64'h0, t);        idle(0); wait_cyc(2);
    check("rdata_kept_after_err", o_rdata[0], 64'hDEADBEEF);
    accept(0, 1'b0, 3'd2, 19'h10, 64'h0, t);        idle(0); wait_cyc(3);
    check("rd_subword", o_rdata[0], 64'h5566BEEF);

    accept(0, 1'b1, 3'd2, 19'h20, {$urandom, $urandom}, t1);
    accept(0, 1'b1, 3'd2, 19'h24, {$urandom, $urandom}, t2);
    accept(0, 1'b1, 3'd2, 19'h28, {$urandom, $urandom}, t3);
    accept(0, 1'b0, 3'd2, 19'h24, 64'h0, t4);
    idle(0); wait_cyc(4);
    check("b2b_wr_gap", 64'(t3 - t1), 64'd2);
    check("rd_in_wr_ack", 64'(t4 - t3), 64'd1);

    b_busy[0] = 1'b1;
    b_req[0] = 1'b1; b_write[0] = 1'b1; b_size[0] = 3'd2; b_addr[0] = 19'h30; b_wdata[0] = 64'h0BAD_F00D;
    wait_cyc(3);
    b_busy[0] = 1'b0;
    t1 = cyc;
    accept(0, 1'b1, 3'd2, 19'h30, 64'h0BAD_F00D, t);
    idle(0); wait_cyc(2);
    check("busy_release_accept", 64'(t), 64'(t1));

    accept(1, 1'b1, 3'd3, 19'h08, 64'h0123_4567_89AB_CDEF, t); idle(1); wait_cyc(2);
    accept(1, 1'b0, 3'd3, 19'h08, 64'h0, t);                   idle(1); wait_cyc(5);
    check("rd64_dword", o_rdata[1], 64'h0123_4567_89AB_CDEF);
    accept(1, 1'b1, 3'd3, 19'h0C, 64'h0, t);                   idle(1); wait_cyc(2);

    accept(1, 1'b0, 3'd3, 19'h08, 64'h0, t);
    idle(1);
    exp_q.delete();
    exp_rd[0] = '0; exp_rd[1] = '0;
    aresetn = 1'b0;
    @(negedge clk);
    check("midrst_rdata1", o_rdata[1], 64'd0);
    check("midrst_rdata0", o_rdata[0], 64'd0);
    check("midrst_state1", 64'(o_state[1]), 64'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    wait_cyc(6);
    accept(1, 1'b0, 3'd3, 19'h08, 64'h0, t); idle(1); wait_cyc(5);
    check("rd64_after_rst", o_rdata[1], 64'h0123_4567_89AB_CDEF);

    s = $urandom_range(0, 1);
    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 3));
      ad = 19'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((19'd1 << sz) - 19'd1);
      accept(s, wr, sz, ad, {$urandom, $urandom}, t);
      ns = $urandom_range(0, 1);
      if (ns != s || $urandom_range(0, 1) == 1) begin
        idle(s);
        wait_cyc($urandom_range(0, 2));
      end
      s = ns;
    end
    idle(0); idle(1);
    wait_cyc(8);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
